shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one parameter: SKIP_ZERO, default 1; 1 = skip shift stages whose shamt bit is 0, 0 = fixed five-stage latency.
REQ-002 The block SHALL have port clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high at a clock edge.
REQ-006 The block SHALL have port data_in, input, 32 bits: operand.
REQ-007 The block SHALL have port shamt, input, 5 bits: shift amount, 0-31.
REQ-008 The block SHALL have port shift_op, input, 2 bits: 00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port data_out, output, 32 bits: result.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE; in_ready SHALL be high only in IDLE.
REQ-014 On acceptance, the block SHALL latch data_in into an accumulator and latch shamt and shift_op.
- Stage pointer set to the highest stage to process; stage weights are 16, 8, 4, 2, 1 (bit 4 to bit 0).
REQ-015 In SHIFT, the block SHALL process one stage per cycle.
- Stage bit set: accumulator shifted by the stage weight in the latched direction.
- Stage bit clear: accumulator unchanged.
- Stage pointer then advances to the next lower stage.
REQ-016 With SKIP_ZERO = 0, the block SHALL visit all 5 stages.
- out_valid rises exactly 5 edges after the acceptance edge.
REQ-017 With SKIP_ZERO = 1, the block SHALL visit only the stages whose shamt bit is set.
- Latency = popcount(shamt) edges after acceptance.
- shamt = 0: the acceptance edge goes IDLE -> DONE directly, and out_valid is high after that edge.
REQ-018 After the last stage, the block SHALL move to DONE and drive the accumulator on data_out with out_valid high.
REQ-019 In DONE, data_out and out_valid SHALL stay stable until out_ready is high at an edge; that edge returns the FSM to IDLE.
- No new request is accepted on that same edge.
REQ-020 Fill rules SHALL be as follows.
- SLL: zero-fill from the LSB side.
- SRL: zero-fill from the MSB side.
- SRA: fill with bit 31 of the latched operand (subject to REQ-025).
- shift_op = 11: processed as SLL.
REQ-021 Inputs SHALL be ignored outside IDLE; in_valid held high while busy has no effect until in_ready rises.
REQ-022 data_out SHALL be 0 in IDLE and SHIFT.

Reset
REQ-023 When reset_n is low, the block SHALL immediately force the following, independent of clock:
- state = IDLE;
- out_valid = 0, data_out = 0, busy = 0, in_ready = 1;
- accumulator, latched shamt, latched op and stage pointer = 0.
REQ-024 A reset asserted mid-operation SHALL discard the in-flight request with no output produced; the first edge after reset_n rises may accept a new request.

Configuration
REQ-025 Macro SHIFT_SEQUENCER_SRA_EN SHALL control arithmetic right shift.
- Defined: shift_op = 10 performs a sign-filling arithmetic right shift.
- Undefined: shift_op = 10 is processed as SRL (zero fill), and no sign-fill logic is synthesized.

Verification
REQ-026 SLL with data_in = 0x000000FF, shamt = 8, SKIP_ZERO = 1 -> data_out = 0x0000FF00, out_valid 1 edge after acceptance.
REQ-027 SRA with data_in = 0x80000000, shamt = 31, macro defined -> 0xFFFFFFFF after 5 edges; macro undefined -> 0x00000001.
REQ-028 SKIP_ZERO = 0, SRL with data_in = 0xF0000000, shamt = 0 -> out_valid exactly 5 edges after acceptance, data_out = 0xF0000000.
REQ-029 Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> data_out stable and in_ready = 0 throughout; one cycle of out_ready -> IDLE, in_ready = 1.
REQ-030 Reset mid-operation: assert reset_n = 0 during SHIFT of shamt = 0x15 -> outputs cleared immediately, no out_valid pulse; a new request with shamt = 0x15 completes after 3 edges (SKIP_ZERO = 1).

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter that walks the five binary
// shift stages (16, 8, 4, 2, 1) one per clock.
//
// Parameter
//   SKIP_ZERO  1: visit only stages whose shamt bit is set (latency = popcount)
//              0: visit all five stages (fixed latency of 5)
//
// Configuration macro
//   SHIFT_SEQUENCER_SRA_EN  defined: shift_op 2'b10 is a sign-filling
//                           arithmetic right shift; undefined: 2'b10 behaves
//                           as a logical right shift with no sign-fill logic.
//
// Ports
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   request present
//   in_ready   high only in IDLE; accept on in_valid & in_ready
//   data_in    32-bit operand
//   shamt      shift amount 0..31
//   shift_op   00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//   out_valid  result held in DONE
//   out_ready  consumer accepts the result; returns the FSM to IDLE
//   data_out   result in DONE, zero otherwise
//   busy       high whenever the FSM is not IDLE
module shift_sequencer #(
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic [1:0]  shift_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned PW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   shamt_q, shamt_d;
  logic [1:0]      op_q, op_d;
  logic [PW-1:0]   stage_q, stage_d;

  logic [SW-1:0]   step_amt;
  logic [SW-1:0]   remaining;
  logic [DW-1:0]   shifted;

  // Index of the most significant set bit (0 when v is zero).
  function automatic logic [PW-1:0] top_bit(input logic [SW-1:0] v);
    top_bit = '0;
    for (int i = 0; i < int'(SW); i++) begin
      if (v[i]) top_bit = PW'(i);
    end
  endfunction

  // Stage weight as a one-hot mask, and the shamt bits still to be visited.
  always_comb begin : stage_decode
    step_amt  = SW'(5'd1 << stage_q);
    remaining = shamt_q & SW'(step_amt - 5'd1);
  end

  // One stage of the shifter in the latched direction.
  always_comb begin : shift_stage
    shifted = acc_q << step_amt;
    if (op_q == 2'b01) shifted = acc_q >> step_amt;
    if (op_q == 2'b10) begin
`ifdef SHIFT_SEQUENCER_SRA_EN
      // Repeated arithmetic shifts keep bit 31 equal to the original sign.
      shifted = $unsigned($signed(acc_q) >>> step_amt);
`else
      shifted = acc_q >> step_amt;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      stage_q <= stage_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin : next_state
    state_d = state_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    stage_d = stage_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = data_in;
          shamt_d = shamt;
          op_d    = shift_op;
          if (SKIP_ZERO != 0) begin
            if (shamt == '0) begin
              stage_d = '0;
              state_d = ST_DONE;
            end else begin
              stage_d = top_bit(shamt);
              state_d = ST_SHIFT;
            end
          end else begin
            stage_d = PW'(SW - 1);
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if ((shamt_q & step_amt) != '0) acc_d = shifted;
        if (SKIP_ZERO != 0) begin
          if (remaining == '0) begin
            stage_d = '0;
            state_d = ST_DONE;
          end else begin
            stage_d = top_bit(remaining);
          end
        end else begin
          if (stage_q == '0) begin
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q - PW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; reset forces them at once.
  always_comb begin : outputs
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    data_out  = (state_q == ST_DONE) ? acc_q : '0;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: runs a SKIP_ZERO=1 and a SKIP_ZERO=0 instance
// side by side on shared inputs and compares both against a shift model.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  shift_op;
  logic        out_ready;

  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [1:0]  bsy;
  logic [31:0] dout [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_sequencer #(.SKIP_ZERO(1)) u_skip (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .data_in(data_in), .shamt(shamt), .shift_op(shift_op), .out_valid(vld[0]),
    .out_ready(out_ready), .data_out(dout[0]), .busy(bsy[0])
  );

  shift_sequencer #(.SKIP_ZERO(0)) u_full (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .data_in(data_in), .shamt(shamt), .shift_op(shift_op), .out_valid(vld[1]),
    .out_ready(out_ready), .data_out(dout[1]), .busy(bsy[1])
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] op);
    case (op)
      2'b01: return d >> s;
      2'b10: begin
`ifdef SHIFT_SEQUENCER_SRA_EN
        return 32'($signed(d) >>> s);
`else
        return d >> s;
`endif
      end
      default: return d << s;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_in_ready"}, 32'(rdy[k]), 32'd1);
      check({tag, "_out_valid"}, 32'(vld[k]), 32'd0);
      check({tag, "_busy"}, 32'(bsy[k]), 32'd0);
      check({tag, "_data_out"}, dout[k], 32'd0);
    end
  endtask

  // One request through both instances; hold = extra cycles of out_ready=0.
  task automatic run_txn(input string tag, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] op, input logic [31:0] exp_d,
                         input int exp_lat, input int hold);
    int lat [2];
    int edges;
    int n;
    @(negedge clock);
    n = 0;
    while (rdy != 2'b11 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle_wait"}, 32'(rdy), 32'h3);
    data_in  = d;
    shamt    = s;
    shift_op = op;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    // Garbage inputs with in_valid held high must be ignored while busy.
    data_in  = $urandom;
    shamt    = 5'($urandom);
    shift_op = 2'($urandom);
    lat[0] = -1;
    lat[1] = -1;
    edges  = 0;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (vld[k] && lat[k] < 0) lat[k] = edges;
        check({tag, "_busy_in_ready"}, 32'(rdy[k]), 32'd0);
        check({tag, "_data_out"}, dout[k], vld[k] ? exp_d : 32'd0);
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
      @(posedge clock);
      @(negedge clock);
      edges++;
    end
    check({tag, "_lat_skip"}, 32'(lat[0]), 32'(exp_lat));
    check({tag, "_lat_full"}, 32'(lat[1]), 32'd5);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        check({tag, "_hold_valid"}, 32'(vld[k]), 32'd1);
        check({tag, "_hold_data"}, dout[k], exp_d);
        check({tag, "_hold_in_ready"}, 32'(rdy[k]), 32'd0);
      end
    end
    // in_valid stays high across the release edge: it must not be accepted.
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle({tag, "_release"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_00FF, 5'd8,  2'b00, 32'h0000_FF00, 1, 10};
`ifdef SHIFT_SEQUENCER_SRA_EN
    vecs[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 5, 0};
    vecs[6] = '{32'hC000_0000, 5'd3,  2'b10, 32'hF800_0000, 2, 1};
`else
    vecs[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001, 5, 0};
    vecs[6] = '{32'hC000_0000, 5'd3,  2'b10, 32'h1800_0000, 2, 1};
`endif
    vecs[2] = '{32'hF000_0000, 5'd0,  2'b01, 32'hF000_0000, 0, 0};
    vecs[3] = '{32'h1234_5678, 5'd4,  2'b11, 32'h2345_6780, 1, 0};
    vecs[4] = '{32'h8000_0001, 5'd1,  2'b01, 32'h4000_0000, 1, 2};
    vecs[5] = '{32'hDEAD_BEEF, 5'd31, 2'b00, 32'h8000_0000, 5, 0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shamt     = '0;
    shift_op  = '0;
    out_ready = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].op,
              vecs[i].exp, vecs[i].lat, vecs[i].hold);
    end

    // Reset in the middle of a shamt=0x15 request.
    @(negedge clock);
    data_in  = 32'h0000_0003;
    shamt    = 5'h15;
    shift_op = 2'b00;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    check("midrst_busy_before", 32'(bsy), 32'h3);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("midrst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midrst_no_valid", 32'(vld), 32'h0);
    end
    reset_n = 1'b1;
    run_txn("after_rst", 32'h0000_0003, 5'h15, 2'b00, 32'h0060_0000, 3, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  op;
      d  = $urandom;
      s  = 5'($urandom);
      op = 2'($urandom);
      run_txn($sformatf("rnd%0d", i), d, s, op, model(d, s, op),
              $countones(s), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
